rot_ctrl: RTL and testbench

//  Operator-control front end for the rotating-square display. Debounces two pushbuttons
//  (run/pause, direction) and produces the count-enable strobe and direction select that

---
 rtl/rot_pkg.sv | 17 +
 rtl/btn_debounce.sv | 41 ++++
 rtl/rot_ctrl.sv | 87 ++++++++
 tb/tb_rot_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotating-square operator-control front end:
// FSM encoding, default debounce width and the prescaler wrap limit.
package rot_pkg;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int DB_N_DEFAULT = 20;

  // Wrap value of the prescaler for a given speed select: en every 2^s cycles.
  function automatic logic [3:0] lim(input logic [1:0] s);
    return (4'd1 << s) - 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stable-level debouncer and a
// one-cycle press tick on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DB_N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press_tick
);

  logic            sync_a;
  logic            sync_b;
  logic [DB_N-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      press_tick <= 1'b0;
    end else begin
      sync_a     <= btn_raw;
      sync_b     <= sync_a;
      press_tick <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        // Level accepted; the tick is raised together with the new level.
        level      <= sync_b;
        cnt        <= '0;
        press_tick <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rot_ctrl.sv
// Operator-control front end: run/pause FSM, direction toggle and the
// speed-scaled count-enable strobe for the rotation stages.
module rot_ctrl
  import rot_pkg::*;
#(
  parameter int DB_N  = DB_N_DEFAULT,
  parameter int PRE_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic [1:0] sw_speed,
  output logic       en,
  output logic       cw,
  output logic       running
);

  state_t           state;
  state_t           state_next;
  logic             run_tick;
  logic             dir_tick;
  logic             run_level_unused;
  logic             dir_level_unused;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] limit;
  logic             en_q;
  logic             cw_q;

  btn_debounce #(.DB_N(DB_N)) u_db_run (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_run),
    .level      (run_level_unused),
    .press_tick (run_tick)
  );

  btn_debounce #(.DB_N(DB_N)) u_db_dir (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_dir),
    .level      (dir_level_unused),
    .press_tick (dir_tick)
  );

  assign limit = PRE_W'(lim(sw_speed));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (run_tick) begin
      state_next = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  always_comb begin
    running = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre  <= '0;
      en_q <= 1'b0;
      cw_q <= 1'b0;
    end else begin
      en_q <= 1'b0;
      if (dir_tick) begin
        // No step on the direction boundary; the new direction restarts the phase.
        pre  <= '0;
        cw_q <= ~cw_q;
      end else if (state == ST_RUN) begin
        if (pre >= limit) pre <= '0;
        else              pre <= pre + 1'b1;
        // Suppress a strobe that would land in the first PAUSE cycle.
        en_q <= (pre == limit) && (state_next == ST_RUN);
      end
    end
  end

  assign en = en_q;
  assign cw = cw_q;

endmodule

// File: tb/tb_rot_ctrl.sv
// Directed self-checking bench for rot_ctrl with a 16-cycle debounce window.
module tb_rot_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run;
  logic       btn_dir;
  logic [1:0] sw_speed;
  logic       en;
  logic       cw;
  logic       running;

  int checks = 0;
  int errors = 0;

  rot_ctrl #(.DB_N(4), .PRE_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_run  (btn_run),
    .btn_dir  (btn_dir),
    .sw_speed (sw_speed),
    .en       (en),
    .cw       (cw),
    .running  (running)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_run = 1'b0; btn_dir = 1'b0; sw_speed = 2'd0;
    repeat (3) step();
    checks++; if (en !== 1'b0)      begin errors++; $display("FAIL reset_en got %b want 0", en); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_running got %b want 1", running); end
    checks++; if (cw !== 1'b0)      begin errors++; $display("FAIL reset_cw got %b want 0", cw); end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (en !== 1'b1) begin errors++; $display("FAIL speed0_en step %0d got %b want 1", i, en); end
    end
  endtask

  task automatic test_speed();
    int pulses;
    sw_speed = 2'd2;
    pulses = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (en === 1'b1) pulses++;
      if (i == 4) begin
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL speed2_phase got %b want 1", en); end
      end
    end
    checks++; if (pulses != 16) begin errors++; $display("FAIL speed2_count got %0d want 16", pulses); end
    sw_speed = 2'd3;
    pulses = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (en === 1'b1) pulses++;
    end
    checks++; if (pulses != 8) begin errors++; $display("FAIL speed3_count got %0d want 8", pulses); end
  endtask

  task automatic test_pause_resume();
    int pulses;
    sw_speed = 2'd2;
    btn_run  = 1'b1;
    pulses   = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 16) begin
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL pause_prephase got %b want 1", en); end
      end
      if (i == 18) begin
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_early got %b want 1", running); end
      end
      if (i == 19) begin
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b want 0", running); end
      end
      if (i >= 19 && en === 1'b1) pulses++;
    end
    btn_run = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (en === 1'b1) pulses++;
    end
    checks++; if (pulses != 0)      begin errors++; $display("FAIL pause_en_pulses got %0d want 0", pulses); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_hold got %b want 0", running); end
    btn_run = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 19) begin
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running got %b want 1", running); end
        checks++; if (en !== 1'b0)      begin errors++; $display("FAIL resume_en19 got %b want 0", en); end
      end
      if (i == 20) begin
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL resume_phase got %b want 1", en); end
      end
      if (i >= 21 && i <= 23) begin
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL resume_gap step %0d got %b want 0", i, en); end
      end
      if (i == 24) begin
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL resume_period got %b want 1", en); end
      end
    end
    btn_run = 1'b0;
    repeat (40) step();
  endtask

  task automatic test_direction();
    sw_speed = 2'd0;
    repeat (5) step();
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL dir_pre_en got %b want 1", en); end
    btn_dir = 1'b1;
    repeat (10) step();
    btn_dir = 1'b0;
    repeat (30) step();
    checks++; if (cw !== 1'b0) begin errors++; $display("FAIL dir_glitch got %b want 0", cw); end
    btn_dir = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 18) begin
        checks++; if (cw !== 1'b0) begin errors++; $display("FAIL dir_early got %b want 0", cw); end
      end
      if (i == 19) begin
        checks++; if (cw !== 1'b1) begin errors++; $display("FAIL dir_toggle got %b want 1", cw); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL dir_en_gap got %b want 0", en); end
      end
      if (i == 20) begin
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL dir_en_after got %b want 1", en); end
      end
    end
    btn_dir = 1'b0;
    repeat (40) step();
    checks++; if (cw !== 1'b1) begin errors++; $display("FAIL dir_once got %b want 1", cw); end
  endtask

  task automatic test_back_to_back();
    btn_run = 1'b1;
    btn_dir = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 18) begin
        checks++; if (running !== 1'b1 || cw !== 1'b1) begin
          errors++; $display("FAIL both_early got running=%b cw=%b want 1 1", running, cw);
        end
      end
      if (i == 19) begin
        checks++; if (running !== 1'b0 || cw !== 1'b0) begin
          errors++; $display("FAIL both_flip got running=%b cw=%b want 0 0", running, cw);
        end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL both_en got %b want 0", en); end
      end
    end
    btn_run = 1'b0;
    btn_dir = 1'b0;
    repeat (40) step();
  endtask

  task automatic test_reset_mid_debounce();
    btn_dir = 1'b1;
    repeat (12) step();
    reset = 1'b1;
    step();
    checks++; if (running !== 1'b1 || cw !== 1'b0 || en !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got running=%b cw=%b en=%b want 1 0 0", running, cw, en);
    end
    reset = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (i == 1) begin
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL midreset_en got %b want 1", en); end
      end
      if (i == 17 || i == 18) begin
        checks++; if (cw !== 1'b0) begin errors++; $display("FAIL midreset_early step %0d got %b want 0", i, cw); end
      end
      if (i == 19) begin
        checks++; if (cw !== 1'b1) begin errors++; $display("FAIL midreset_tick got %b want 1", cw); end
      end
    end
    btn_dir = 1'b0;
    repeat (40) step();
  endtask

  initial begin
    test_reset();
    test_speed();
    test_pause_resume();
    test_direction();
    test_back_to_back();
    test_reset_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
